// File: rtl/dcache_write_buffer.sv
// Write buffer between the data cache and slow data memory: absorbs writebacks, forwards reads, drains in order.
// Optional macro WBUF_COALESCE_EN: writes hitting a buffered (non in-flight) line overwrite it in place.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE} mstate_t;

  mstate_t             mstate_q, mstate_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                cache_ready_q, cache_ready_d;
  logic [LINE_W-1:0]   cache_rdata_q, cache_rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0]   line_addr_mem [DEPTH];
  logic [LINE_W-1:0]   line_data_mem [DEPTH];

  logic [DEPTH-1:0]    addr_match;
  logic                fwd_hit;
  logic [PW-1:0]       fwd_idx;
  logic                coal_hit;
  logic [PW-1:0]       coal_idx;
  logic                inflight;
  logic                req_ok;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic [PW-1:0]       wr_idx;

  assign inflight = (mstate_q == M_WRITE);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign addr_match[gi] = valid_q[gi] && (line_addr_mem[gi] == cache_addr);
    end
  endgenerate

  // Scan oldest to youngest so the last hit wins: that is the youngest copy.
  always_comb begin
    logic [PW-1:0] scan_idx;
    fwd_hit  = 1'b0;
    fwd_idx  = head_q;
    scan_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (addr_match[scan_idx]) begin
        fwd_hit = 1'b1;
        fwd_idx = scan_idx;
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  // The line being written to memory must stay frozen, so it is excluded.
  always_comb begin
    logic [PW-1:0] scan_idx;
    coal_hit = 1'b0;
    coal_idx = head_q;
    scan_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (addr_match[scan_idx] && !(inflight && (scan_idx == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  always_comb begin
    mstate_d      = mstate_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    valid_d       = valid_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    cache_ready_d = 1'b0;
    cache_rdata_d = cache_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    push          = 1'b0;
    pop           = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = tail_q;

    // A held request is ignored while its completion pulse is out or a miss is in progress.
    req_ok = !cache_ready_q && !rd_pend_q;

    if (req_ok && cache_write) begin
      if (coal_hit) begin
        wr_en         = 1'b1;
        wr_idx        = coal_idx;
        cache_ready_d = 1'b1;
      end else if (count_q < DEPTH_C) begin
        wr_en         = 1'b1;
        wr_idx        = tail_q;
        push          = 1'b1;
        cache_ready_d = 1'b1;
      end
    end else if (req_ok && cache_read) begin
      if (fwd_hit) begin
        cache_rdata_d = line_data_mem[fwd_idx];
        cache_ready_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = cache_addr;
      end
    end

    case (mstate_q)
      M_IDLE: begin
        if (rd_pend_q) begin
          mstate_d   = M_READ;
          mem_read_d = 1'b1;
          mem_addr_d = rd_addr_q;
        end else if (count_q != '0) begin
          mstate_d    = M_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = line_addr_mem[head_q];
          mem_wdata_d = line_data_mem[head_q];
        end
      end
      M_READ: begin
        if (mem_ready) begin
          mstate_d      = M_IDLE;
          mem_read_d    = 1'b0;
          cache_rdata_d = mem_rdata;
          cache_ready_d = 1'b1;
          rd_pend_d     = 1'b0;
        end
      end
      M_WRITE: begin
        if (mem_ready) begin
          mstate_d    = M_IDLE;
          mem_write_d = 1'b0;
          pop         = 1'b1;
        end
      end
      default: mstate_d = M_IDLE;
    endcase

    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mstate_q      <= M_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      mstate_q      <= mstate_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      cache_ready_q <= cache_ready_d;
      cache_rdata_q <= cache_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Line storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_addr_mem[wr_idx] <= cache_addr;
      line_data_mem[wr_idx] <= cache_wdata;
    end
  end

  assign cache_ready = cache_ready_q;
  assign cache_rdata = cache_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
